// File: rtl/step_pulse_gen_pkg.sv
// Shared motion definitions: FSM state encoding, default timing-field width
// and the endstop blocking rule.
package step_pulse_gen_pkg;

  localparam int unsigned STEP_CNT_W_DEFAULT = 8;
  localparam int unsigned STEP_POS_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } step_state_e;

  // A step towards an asserted endstop must never reach the driver.
  function automatic logic dir_blocked(input logic dir, input logic e_min,
                                       input logic e_max);
    return (!dir && e_min) || (dir && e_max);
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Step request handshake between the motion core (master) and the pulse generator.
interface step_pulse_gen_if;
  logic Req_Step;
  logic Req_Dir;
  logic Req_Ready;

  modport master (output Req_Step, output Req_Dir, input Req_Ready);
  modport slave  (input Req_Step, input Req_Dir, output Req_Ready);
endinterface

// File: rtl/step_pulse_gen.sv
// Stepper driver pulse generator: dir-setup / pulse / hold sequencing on one shared
// down-counter, endstop blocking, signed position tracking and sticky error flags.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = STEP_CNT_W_DEFAULT
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Resetn,
  step_pulse_gen_if.slave       req,
  input  logic [CNT_W-1:0]      Cfg_Setup,
  input  logic [CNT_W-1:0]      Cfg_Width,
  input  logic [CNT_W-1:0]      Cfg_Hold,
  input  logic                  Cfg_Enable,
  input  logic                  E_Min,
  input  logic                  E_Max,
  input  logic                  Pos_Load,
  input  logic [STEP_POS_W-1:0] Pos_Data,
  input  logic                  Clr_Err,
  output logic                  S_Step,
  output logic                  S_Dir,
  output logic                  S_Enable,
  output logic [STEP_POS_W-1:0] Pos,
  output logic                  Err_Overrun,
  output logic                  Err_Blocked
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  step_state_e           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      width_q;
  logic [CNT_W-1:0]      hold_q;
  logic                  live_q;
  logic                  step_q;
  logic                  dir_q;
  logic                  en_q;
  logic                  ovr_q, ovr_d;
  logic                  blk_q, blk_d;
  logic [STEP_POS_W-1:0] pos_q, pos_d;

  logic ready;
  logic accept;
  logic blocked;
  logic go;
  logic setup_done;
  logic enter_pulse;
  logic entry_dir;

  // Counter preload for an N-cycle phase, with zero treated as one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  // live_q keeps the handshake closed until the first edge after reset release.
  assign ready         = live_q & Cfg_Enable & (state_q == ST_IDLE);
  assign req.Req_Ready = ready;
  assign accept        = req.Req_Step & ready;
  assign blocked       = accept & dir_blocked(req.Req_Dir, E_Min, E_Max);
  assign go            = accept & ~blocked;
  assign setup_done    = (state_q == ST_SETUP) && (cnt_q == '0);
  assign enter_pulse   = Cfg_Enable & ((go & (req.Req_Dir == dir_q)) | setup_done);
  assign entry_dir     = setup_done ? dir_q : req.Req_Dir;

  always_comb begin
    pos_d = pos_q;
    if (enter_pulse) begin
      pos_d = entry_dir ? pos_q + 32'd1 : pos_q - 32'd1;
    end
    if (Pos_Load) begin
      pos_d = Pos_Data;
    end
    ovr_d = (req.Req_Step & ~ready) | (ovr_q & ~Clr_Err);
    blk_d = blocked | (blk_q & ~Clr_Err);
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      hold_q  <= '0;
      live_q  <= 1'b0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      ovr_q   <= 1'b0;
      blk_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      live_q <= 1'b1;
      en_q   <= Cfg_Enable;
      ovr_q  <= ovr_d;
      blk_q  <= blk_d;
      pos_q  <= pos_d;
      if (!Cfg_Enable) begin
        state_q <= ST_IDLE;
        step_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (go) begin
              dir_q   <= req.Req_Dir;
              width_q <= Cfg_Width;
              hold_q  <= Cfg_Hold;
              if (req.Req_Dir != dir_q) begin
                state_q <= ST_SETUP;
                cnt_q   <= phase_load(Cfg_Setup);
              end else begin
                state_q <= ST_PULSE;
                step_q  <= 1'b1;
                cnt_q   <= phase_load(Cfg_Width);
              end
            end
          end
          ST_SETUP: begin
            if (cnt_q == '0) begin
              state_q <= ST_PULSE;
              step_q  <= 1'b1;
              cnt_q   <= phase_load(width_q);
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          ST_PULSE: begin
            if (cnt_q == '0) begin
              step_q <= 1'b0;
              if (hold_q == '0) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_HOLD;
                cnt_q   <= hold_q - CNT_ONE;
              end
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          ST_HOLD: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign S_Step      = step_q;
  assign S_Dir       = dir_q;
  assign S_Enable    = en_q;
  assign Pos         = pos_q;
  assign Err_Overrun = ovr_q;
  assign Err_Blocked = blk_q;

endmodule
